// File: rtl/t05_translation_encode.sv
// t05_translation_encode
// Reads uncompressed characters over a SPI-style byte source, fetches each
// character's code path from a codebook SRAM, and packs the path bits
// MSB-first into bytes written to a SPI-style sink with a ready handshake.
// A partially filled final byte is zero-padded and flushed.
//
// Optional feature: define T05_TRANSLATION_BITCOUNT_EN to add the total_bits
// output, which counts every emitted path bit (padding excluded).
//
// Reset: rst is asynchronous and active-low.
module t05_translation_encode (
    input  logic         clk,
    input  logic         rst,
    input  logic         translation_enable,
    input  logic [31:0]  tot_chars,
    output logic         SPI_read_en,
    input  logic         SPI_data_valid,
    input  logic [7:0]   SPI_data_in,
    output logic         SRAM_read_en,
    output logic [7:0]   char_index,
    input  logic         SRAM_data_valid,
    input  logic [127:0] SRAM_data_in,
    input  logic [7:0]   SRAM_len_in,
    output logic [7:0]   SPI_data_out,
    output logic         SPI_write_en,
    input  logic         SPI_write_ready,
    output logic         finished,
    output logic [31:0]  chars_done
`ifdef T05_TRANSLATION_BITCOUNT_EN
    ,
    output logic [31:0]  total_bits
`endif
);

    typedef enum logic [3:0] {
        INIT,
        READ_SPI_CHAR,
        WAIT_SPI,
        READ_SRAM_PATH,
        WAIT_SRAM,
        EMIT_BITS,
        WRITE_BYTE,
        FLUSH,
        FINISH
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    tot_reg, tot_next;
    logic [7:0]     char_reg, char_next;
    logic [127:0]   path_reg, path_next;
    logic [7:0]     bits_left_reg, bits_left_next;
    logic [7:0]     byte_reg, byte_next;
    logic [3:0]     bit_fill_reg, bit_fill_next;
    logic [31:0]    chars_done_reg, chars_done_next;
    logic           last_char;
`ifdef T05_TRANSLATION_BITCOUNT_EN
    logic [31:0]    total_bits_reg, total_bits_next;
`endif

    // The character being finished now is the final one of the run.
    assign last_char = ((chars_done_reg + 32'd1) == tot_reg);

    // State and datapath registers; rst aborts immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= INIT;
            tot_reg        <= '0;
            char_reg       <= '0;
            path_reg       <= '0;
            bits_left_reg  <= '0;
            byte_reg       <= '0;
            bit_fill_reg   <= '0;
            chars_done_reg <= '0;
`ifdef T05_TRANSLATION_BITCOUNT_EN
            total_bits_reg <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            tot_reg        <= tot_next;
            char_reg       <= char_next;
            path_reg       <= path_next;
            bits_left_reg  <= bits_left_next;
            byte_reg       <= byte_next;
            bit_fill_reg   <= bit_fill_next;
            chars_done_reg <= chars_done_next;
`ifdef T05_TRANSLATION_BITCOUNT_EN
            total_bits_reg <= total_bits_next;
`endif
        end
    end

    // Next-state, datapath updates and request strobes.
    always_comb begin
        state_next      = state_reg;
        tot_next        = tot_reg;
        char_next       = char_reg;
        path_next       = path_reg;
        bits_left_next  = bits_left_reg;
        byte_next       = byte_reg;
        bit_fill_next   = bit_fill_reg;
        chars_done_next = chars_done_reg;
`ifdef T05_TRANSLATION_BITCOUNT_EN
        total_bits_next = total_bits_reg;
`endif
        SPI_read_en     = 1'b0;
        SRAM_read_en    = 1'b0;
        SPI_write_en    = 1'b0;
        finished        = 1'b0;

        case (state_reg)
            INIT: begin
                if (translation_enable) begin
                    tot_next        = tot_chars;
                    chars_done_next = '0;
`ifdef T05_TRANSLATION_BITCOUNT_EN
                    total_bits_next = '0;
`endif
                    state_next      = (tot_chars == 32'd0) ? FINISH : READ_SPI_CHAR;
                end
            end

            READ_SPI_CHAR: begin
                SPI_read_en = 1'b1;
                state_next  = WAIT_SPI;
            end

            WAIT_SPI: begin
                if (SPI_data_valid) begin
                    char_next  = SPI_data_in;
                    state_next = READ_SRAM_PATH;
                end
            end

            READ_SRAM_PATH: begin
                SRAM_read_en = 1'b1;
                state_next   = WAIT_SRAM;
            end

            WAIT_SRAM: begin
                if (SRAM_data_valid) begin
                    path_next      = SRAM_data_in;
                    bits_left_next = (SRAM_len_in > 8'd128) ? 8'd128 : SRAM_len_in;
                    state_next     = EMIT_BITS;
                end
            end

            EMIT_BITS: begin
                if (bits_left_reg == 8'd0) begin
                    // Zero-length code: the character completes with no bits.
                    chars_done_next = chars_done_reg + 32'd1;
                    state_next      = last_char ? FLUSH : READ_SPI_CHAR;
                end else begin
                    // 7 - bit_fill for a 3-bit fill is its bitwise inverse.
                    byte_next[~bit_fill_reg[2:0]] = path_reg[127];
                    path_next      = {path_reg[126:0], 1'b0};
                    bits_left_next = bits_left_reg - 8'd1;
                    bit_fill_next  = bit_fill_reg + 4'd1;
`ifdef T05_TRANSLATION_BITCOUNT_EN
                    total_bits_next = total_bits_reg + 32'd1;
`endif
                    if (bit_fill_reg == 4'd7) begin
                        // Byte full takes priority over char completion.
                        state_next = WRITE_BYTE;
                    end else if (bits_left_reg == 8'd1) begin
                        chars_done_next = chars_done_reg + 32'd1;
                        state_next      = last_char ? FLUSH : READ_SPI_CHAR;
                    end
                end
            end

            WRITE_BYTE: begin
                SPI_write_en = 1'b1;
                if (SPI_write_ready) begin
                    byte_next     = '0;
                    bit_fill_next = '0;
                    if (bits_left_reg != 8'd0) begin
                        state_next = EMIT_BITS;
                    end else begin
                        chars_done_next = chars_done_reg + 32'd1;
                        state_next      = last_char ? FLUSH : READ_SPI_CHAR;
                    end
                end
            end

            FLUSH: begin
                // Unused low bits are already zero since the byte was
                // cleared on the previous write.
                if (bit_fill_reg == 4'd0) begin
                    state_next = FINISH;
                end else begin
                    SPI_write_en = 1'b1;
                    if (SPI_write_ready) begin
                        byte_next     = '0;
                        bit_fill_next = '0;
                        state_next    = FINISH;
                    end
                end
            end

            FINISH: begin
                finished = 1'b1;
            end

            default: begin
                state_next = INIT;
            end
        endcase

        // Dropping the enable abandons everything, including a partial byte.
        if (!translation_enable) begin
            state_next      = INIT;
            tot_next        = '0;
            char_next       = '0;
            path_next       = '0;
            bits_left_next  = '0;
            byte_next       = '0;
            bit_fill_next   = '0;
            chars_done_next = '0;
`ifdef T05_TRANSLATION_BITCOUNT_EN
            total_bits_next = '0;
`endif
        end
    end

    assign char_index   = char_reg;
    assign SPI_data_out = byte_reg;
    assign chars_done   = chars_done_reg;
`ifdef T05_TRANSLATION_BITCOUNT_EN
    assign total_bits   = total_bits_reg;
`endif

endmodule

// File: tb/tb_t05_translation_encode.sv
// Directed testbench for t05_translation_encode (default build).
module tb_t05_translation_encode;

    logic         clk;
    logic         rst;
    logic         translation_enable;
    logic [31:0]  tot_chars;
    logic         SPI_read_en;
    logic         SPI_data_valid;
    logic [7:0]   SPI_data_in;
    logic         SRAM_read_en;
    logic [7:0]   char_index;
    logic         SRAM_data_valid;
    logic [127:0] SRAM_data_in;
    logic [7:0]   SRAM_len_in;
    logic [7:0]   SPI_data_out;
    logic         SPI_write_en;
    logic         SPI_write_ready;
    logic         finished;
    logic [31:0]  chars_done;

    int errors = 0;
    int checks = 0;

    // Bench-side source, codebook and sink state.
    logic [7:0]   char_q[$];
    logic [7:0]   wr_q[$];
    logic [127:0] cb_path [256];
    logic [7:0]   cb_len [256];
    logic         spi_pend, sram_pend;
    int           rd_pulses, wen_cycles, overlap, stall_left, held, unstable;
    logic [7:0]   hold_val;

    t05_translation_encode dut (
        .clk(clk), .rst(rst), .translation_enable(translation_enable), .tot_chars(tot_chars),
        .SPI_read_en(SPI_read_en), .SPI_data_valid(SPI_data_valid), .SPI_data_in(SPI_data_in),
        .SRAM_read_en(SRAM_read_en), .char_index(char_index), .SRAM_data_valid(SRAM_data_valid),
        .SRAM_data_in(SRAM_data_in), .SRAM_len_in(SRAM_len_in), .SPI_data_out(SPI_data_out),
        .SPI_write_en(SPI_write_en), .SPI_write_ready(SPI_write_ready),
        .finished(finished), .chars_done(chars_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source/codebook responders and sink, all driven on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            SPI_data_valid = 1'b0; SRAM_data_valid = 1'b0;
            spi_pend = 1'b0; sram_pend = 1'b0; SPI_write_ready = 1'b1;
        end else begin
            SPI_data_valid = spi_pend;
            if (spi_pend) SPI_data_in = (char_q.size() > 0) ? char_q.pop_front() : 8'h00;
            spi_pend = SPI_read_en;
            SRAM_data_valid = sram_pend;
            if (sram_pend) begin
                SRAM_data_in = cb_path[char_index];
                SRAM_len_in  = cb_len[char_index];
            end
            sram_pend = SRAM_read_en;
            if (SPI_read_en) rd_pulses++;
            if ((int'(SPI_read_en) + int'(SRAM_read_en) + int'(SPI_write_en)) > 1) overlap++;
            if (SPI_write_en) begin
                wen_cycles++;
                if (stall_left > 0) begin
                    SPI_write_ready = 1'b0;
                    stall_left--;
                    if (held == 0) hold_val = SPI_data_out;
                    else if (SPI_data_out !== hold_val) unstable++;
                    held++;
                end else begin
                    SPI_write_ready = 1'b1;
                    wr_q.push_back(SPI_data_out);
                    $display("write byte %02h (chars_done=%0d)", SPI_data_out, chars_done);
                end
            end else begin
                SPI_write_ready = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_tb;
        translation_enable = 1'b0;
        idle(2);
        char_q.delete(); wr_q.delete();
        rd_pulses = 0; wen_cycles = 0; stall_left = 0; held = 0; unstable = 0; hold_val = 8'h00;
    endtask

    task automatic start(input logic [31:0] n);
        tot_chars = n;
        translation_enable = 1'b1;
    endtask

    task automatic wait_finished(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (finished) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        bit ok;
        rst = 1'b0; translation_enable = 1'b0; tot_chars = 0;
        idle(3);
        checks++; if (SPI_read_en !== 1'b0 || SRAM_read_en !== 1'b0 || SPI_write_en !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b%b exp=000", SPI_read_en, SRAM_read_en, SPI_write_en); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b exp=0", finished); end
        checks++; if (SPI_data_out !== 8'h00 || char_index !== 8'h00) begin errors++; $display("FAIL reset_bytes got=%02h/%02h exp=00/00", SPI_data_out, char_index); end
        checks++; if (chars_done !== 32'd0) begin errors++; $display("FAIL reset_chars_done got=%0d exp=0", chars_done); end
        rst = 1'b1;
        idle(2);
        ok = 1'b1;
    endtask

    task automatic test_zero_chars;
        clear_tb();
        start(0);
        idle(2);
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL zero_finished got=%b exp=1", finished); end
        idle(4);
        checks++; if (finished !== 1'b1) begin errors++; $display("FAIL zero_finished_held got=%b exp=1", finished); end
        checks++; if (rd_pulses !== 0 || wen_cycles !== 0) begin errors++; $display("FAIL zero_pulses got rd=%0d wr=%0d exp 0/0", rd_pulses, wen_cycles); end
    endtask

    task automatic test_single_char;
        bit ok;
        clear_tb();
        char_q.push_back(8'h41);
        start(1);
        wait_finished(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got=%b exp=1", ok); end
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
        checks++; if (wr_q[0] !== 8'hA0) begin errors++; $display("FAIL single_byte got=%02h exp=a0", wr_q[0]); end
        checks++; if (chars_done !== 32'd1) begin errors++; $display("FAIL single_chars_done got=%0d exp=1", chars_done); end
        checks++; if (rd_pulses !== 1) begin errors++; $display("FAIL single_reads got=%0d exp=1", rd_pulses); end
    endtask

    task automatic test_two_chars;
        bit ok;
        clear_tb();
        char_q.push_back(8'h41); char_q.push_back(8'h42);
        start(2);
        wait_finished(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL two_timeout got=%b exp=1", ok); end
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL two_count got=%0d exp=1", wr_q.size()); end
        checks++; if (wr_q[0] !== 8'hAD) begin errors++; $display("FAIL two_byte got=%02h exp=ad", wr_q[0]); end
        checks++; if (chars_done !== 32'd2) begin errors++; $display("FAIL two_chars_done got=%0d exp=2", chars_done); end
    endtask

    task automatic test_len_zero;
        bit ok;
        clear_tb();
        char_q.push_back(8'h44); char_q.push_back(8'h41);
        start(2);
        wait_finished(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL len0_timeout got=%b exp=1", ok); end
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== 8'hA0) begin errors++; $display("FAIL len0_bytes got n=%0d b=%02h exp n=1 b=a0", wr_q.size(), wr_q[0]); end
        checks++; if (chars_done !== 32'd2) begin errors++; $display("FAIL len0_chars_done got=%0d exp=2", chars_done); end
    endtask

    task automatic test_stall;
        bit ok;
        clear_tb();
        char_q.push_back(8'h43);
        stall_left = 5;
        start(1);
        wait_finished(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout got=%b exp=1", ok); end
        checks++; if (held !== 5 || hold_val !== 8'hF0 || unstable !== 0) begin errors++; $display("FAIL stall_hold got held=%0d val=%02h unstable=%0d exp 5/f0/0", held, hold_val, unstable); end
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL stall_count got=%0d exp=2", wr_q.size()); end
        checks++; if (wr_q[0] !== 8'hF0 || wr_q[1] !== 8'hF0) begin errors++; $display("FAIL stall_bytes got=%02h %02h exp=f0 f0", wr_q[0], wr_q[1]); end
    endtask

    task automatic test_clamp;
        bit ok;
        int bad;
        clear_tb();
        char_q.push_back(8'h45);
        start(1);
        wait_finished(ok);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== 8'hC3) bad++;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clamp_timeout got=%b exp=1", ok); end
        checks++; if (wr_q.size() !== 16) begin errors++; $display("FAIL clamp_count got=%0d exp=16", wr_q.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_bytes got %0d non-c3 bytes exp=0", bad); end
    endtask

    task automatic test_abort;
        bit ok;
        clear_tb();
        char_q.push_back(8'h43);
        start(1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (SRAM_read_en) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_sram_req got=%b exp=1", ok); end
        idle(6);
        checks++; if (SPI_data_out !== 8'hF0) begin errors++; $display("FAIL abort_partial got=%02h exp=f0", SPI_data_out); end
        translation_enable = 1'b0;
        @(negedge clk);
        checks++; if (SPI_data_out !== 8'h00 || chars_done !== 32'd0) begin errors++; $display("FAIL abort_cleared got=%02h/%0d exp=00/0", SPI_data_out, chars_done); end
        checks++; if (wen_cycles !== 0 || finished !== 1'b0) begin errors++; $display("FAIL abort_no_write got wr=%0d fin=%b exp 0/0", wen_cycles, finished); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        clear_tb();
        char_q.push_back(8'h42);
        start(1);
        wait_finished(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got=%b exp=1", ok); end
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== 8'h68) begin errors++; $display("FAIL b2b_bytes got n=%0d b=%02h exp n=1 b=68", wr_q.size(), wr_q[0]); end
    endtask

    task automatic test_async_reset;
        bit ok;
        clear_tb();
        char_q.push_back(8'h43);
        stall_left = 20;
        start(1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (SPI_write_en) begin ok = 1'b1; break; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL areset_write_seen got=%b exp=1", ok); end
        #2 rst = 1'b0;
        #1;
        checks++; if (SPI_write_en !== 1'b0 || SPI_data_out !== 8'h00) begin errors++; $display("FAIL areset_immediate got en=%b d=%02h exp 0/00", SPI_write_en, SPI_data_out); end
        checks++; if (char_index !== 8'h00 || chars_done !== 32'd0) begin errors++; $display("FAIL areset_regs got=%02h/%0d exp=00/0", char_index, chars_done); end
        translation_enable = 1'b0;
        idle(2);
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL areset_dropped got=%0d exp=0", wr_q.size()); end
        rst = 1'b1;
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            cb_path[i] = '0;
            cb_len[i]  = 8'd0;
        end
        cb_path[8'h41] = {3'b101, 125'd0};      cb_len[8'h41] = 8'd3;
        cb_path[8'h42] = {5'b01101, 123'd0};    cb_len[8'h42] = 8'd5;
        cb_path[8'h43] = {12'hF0F, 116'd0};     cb_len[8'h43] = 8'd12;
        cb_path[8'h44] = {128{1'b1}};           cb_len[8'h44] = 8'd0;
        cb_path[8'h45] = {16{8'hC3}};           cb_len[8'h45] = 8'd200;
        SPI_data_in = 8'h00; SRAM_data_in = '0; SRAM_len_in = 8'd0;
        SPI_data_valid = 1'b0; SRAM_data_valid = 1'b0; SPI_write_ready = 1'b1;
        spi_pend = 1'b0; sram_pend = 1'b0; overlap = 0;
        rd_pulses = 0; wen_cycles = 0; stall_left = 0; held = 0; unstable = 0; hold_val = 8'h00;

        test_reset();
        test_zero_chars();
        test_single_char();
        test_two_chars();
        test_len_zero();
        test_stall();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_async_reset();

        checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
